// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_stage_reg inter-stage register.
// NOP payload constant, occupancy encoding and a payload field-slice helper.
package pipe_pkg;

    localparam int FIELD_MAX_W   = 64;
    localparam int PAYLOAD_MAX_W = 4096;

    // An empty stage always presents this payload so no stale data leaks downstream.
    localparam logic [PAYLOAD_MAX_W-1:0] NOP_PAYLOAD = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [FIELD_MAX_W-1:0] field_of(
        input logic [PAYLOAD_MAX_W-1:0] payload,
        input int unsigned              k,
        input int unsigned              data_w
    );
        logic [PAYLOAD_MAX_W-1:0] shifted;
        logic [FIELD_MAX_W-1:0]   res;
        shifted = payload >> (k * data_w);
        res     = '0;
        for (int unsigned i = 0; i < FIELD_MAX_W; i++) begin
            if (i < data_w) res[i] = shifted[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage boundary: upstream, hazard controls, downstream, status.
// The master modport is the driving side (upstream/hazard unit/downstream), slave is the stage.
interface pipe_stage_reg_if #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 3,
    parameter int CNT_W      = 16
);
    localparam int PW = DATA_W * NUM_FIELDS;

    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_data;
    logic             stall;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] bubbles;

    modport master (
        output in_valid, in_data, stall, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy, bubbles
    );

    modport slave (
        input  in_valid, in_data, stall, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy, bubbles
    );

endinterface

// File: rtl/pipe_skid_slot.sv
// One payload+valid register; clear wins over load and always zeroes the payload.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int PW = 96
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [PW-1:0] d,
    output logic          valid,
    output logic [PW-1:0] data
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = NOP_PAYLOAD[PW-1:0];
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= NOP_PAYLOAD[PW-1:0];
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready, stall, flush and bubble counter.
// Define PIPE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 3,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stage_reg_if.slave bus
);

    localparam int PW = DATA_W * NUM_FIELDS;

    logic             main_valid, main_load, main_clear;
    logic [PW-1:0]    main_data, main_d;
    logic             in_ready, acc, drn;
    occ_e             occ;
    logic [CNT_W-1:0] bubbles_q, bubbles_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pipe_skid_slot #(.PW(PW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .data  (main_data)
    );

`ifdef PIPE_SKID_EN
    logic          skid_valid, skid_load, skid_clear;
    logic [PW-1:0] skid_data;

    pipe_skid_slot #(.PW(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (bus.in_data),
        .valid (skid_valid),
        .data  (skid_data)
    );

    // Readiness depends only on the skid flop, so out_ready never reaches in_ready.
    always_comb begin
        in_ready   = ~bus.stall & ~bus.flush & ~skid_valid;
        acc        = bus.in_valid & in_ready;
        drn        = main_valid & bus.out_ready;
        main_load  = (acc & (~main_valid | drn)) | (drn & skid_valid);
        main_d     = skid_valid ? skid_data : bus.in_data;
        main_clear = bus.flush | (drn & ~acc & ~skid_valid);
        skid_load  = acc & main_valid & ~drn;
        skid_clear = bus.flush | (drn & skid_valid);
        case ({main_valid, skid_valid})
            2'b11:        occ = OCC_TWO;
            2'b10, 2'b01: occ = OCC_ONE;
            default:      occ = OCC_EMPTY;
        endcase
    end
`else
    always_comb begin
        in_ready   = ~bus.stall & ~bus.flush & (~main_valid | bus.out_ready);
        acc        = bus.in_valid & in_ready;
        drn        = main_valid & bus.out_ready;
        main_load  = acc;
        main_d     = bus.in_data;
        main_clear = bus.flush | (drn & ~acc);
        occ        = main_valid ? OCC_ONE : OCC_EMPTY;
    end
`endif

    // Flush leaves the counter alone; only reset clears it.
    always_comb begin
        bubbles_d = main_valid ? bubbles_q : sat_inc(bubbles_q);
    end

    always_ff @(posedge clk) begin
        if (reset) bubbles_q <= '0;
        else       bubbles_q <= bubbles_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.occupancy = occ;
    assign bus.bubbles   = bubbles_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (DATA_W=8, NUM_FIELDS=3, CNT_W=4); honours PIPE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int DATA_W     = 8;
    localparam int NUM_FIELDS = 3;
    localparam int CNT_W      = 4;
    localparam int PW         = DATA_W * NUM_FIELDS;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       st;
        logic       fl;
        logic       ordy;
        logic       chk_ir;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_d;
        logic [1:0] exp_occ;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic st,
                                input logic fl, input logic ordy, input logic chk_ir,
                                input logic exp_ir, input logic exp_ov,
                                input logic [7:0] exp_d, input logic [1:0] exp_occ);
        vec_t v;
        v.iv = iv; v.d = d; v.st = st; v.fl = fl; v.ordy = ordy;
        v.chk_ir = chk_ir; v.exp_ir = exp_ir; v.exp_ov = exp_ov;
        v.exp_d = exp_d; v.exp_occ = exp_occ;
        return v;
    endfunction

    function automatic logic [PW-1:0] pay(input logic [7:0] v);
        return {~v, v ^ 8'h5A, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic st,
                         input logic fl, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = pay(d);
        bus.stall     = st;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [7:0] f0,
                             input logic [1:0] occ);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, ".out_data"}, 32'(bus.out_data), ov ? 32'(pay(f0)) : 32'd0);
        check({tag, ".occupancy"}, 32'(bus.occupancy), 32'(occ));
    endtask

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // iv  d      st fl ordy chk ir  ov  exp_d  occ
        vecs[0]  = mk(1, 8'h11, 0, 0, 1, 1, 1, 1, 8'h11, 2'd1);
        vecs[1]  = mk(1, 8'h22, 0, 0, 1, 1, 1, 1, 8'h22, 2'd1);
        vecs[2]  = mk(1, 8'h33, 0, 0, 1, 1, 1, 1, 8'h33, 2'd1);
        vecs[3]  = mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 2'd0);
        vecs[4]  = mk(1, 8'h66, 0, 0, 0, 1, 1, 1, 8'h66, 2'd1);
        vecs[5]  = mk(1, 8'h70, 1, 0, 1, 1, 0, 0, 8'h00, 2'd0);
        vecs[6]  = mk(1, 8'h70, 1, 0, 1, 1, 0, 0, 8'h00, 2'd0);
        vecs[7]  = mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 2'd0);
        vecs[8]  = mk(1, 8'h12, 0, 0, 0, 1, 1, 1, 8'h12, 2'd1);
        vecs[9]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h12, 2'd1);
        vecs[10] = mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 2'd0);

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset and idle bubble counting
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset.bubbles", 32'(bus.bubbles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        check("idle.bubbles", 32'(bus.bubbles), 32'd3);
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);

        // Streaming, stall drain and hold vectors
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].st, vecs[i].fl, vecs[i].ordy);
            if (vecs[i].chk_ir)
                check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ir));
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_d, vecs[i].exp_occ);
        end

        // Back-pressure: 0x44 held, 0x55 offered
        drive(1, 8'h44, 0, 0, 0);
        tick();
        check_out("bp.a", 1'b1, 8'h44, 2'd1);
        drive(1, 8'h55, 0, 0, 0);
        check("bp.b.in_ready", 32'(bus.in_ready), SKID ? 32'd1 : 32'd0);
        tick();
        check_out("bp.b", 1'b1, 8'h44, SKID ? 2'd2 : 2'd1);
        drive(1, 8'h55, 0, 0, 1);
        check("bp.c.in_ready", 32'(bus.in_ready), SKID ? 32'd0 : 32'd1);
        check("bp.c.out_data", 32'(bus.out_data), 32'(pay(8'h44)));
        tick();
        check_out("bp.c", 1'b1, 8'h55, 2'd1);
        drive(0, 8'h00, 0, 0, 1);
        tick();
        check_out("bp.d", 1'b0, 8'h00, 2'd0);

        // Flush with a full stage and a payload on offer
        drive(1, 8'h60, 0, 0, 0);
        tick();
        check_out("fl.a", 1'b1, 8'h60, 2'd1);
        drive(1, 8'h61, 0, 0, 0);
        tick();
        check_out("fl.b", 1'b1, 8'h60, SKID ? 2'd2 : 2'd1);
        drive(1, 8'h77, 0, 1, 0);
        check("fl.c.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check_out("fl.c", 1'b0, 8'h00, 2'd0);
        drive(0, 8'h00, 0, 0, 1);
        tick();
        check_out("fl.d", 1'b0, 8'h00, 2'd0);
        drive(1, 8'h78, 0, 0, 1);
        tick();
        check_out("fl.e", 1'b1, 8'h78, 2'd1);
        drive(0, 8'h00, 0, 0, 1);
        tick();
        check_out("fl.f", 1'b0, 8'h00, 2'd0);

        // Bubble counter: flush does not clear, saturation, reset mid-stream
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        check("bub.count3", 32'(bus.bubbles), 32'd3);
        drive(0, 8'h00, 0, 1, 0);
        tick();
        check("bub.flush", 32'(bus.bubbles), 32'd4);
        drive(0, 8'h00, 0, 0, 0);
        repeat (20) tick();
        check("bub.sat", 32'(bus.bubbles), 32'hF);
        drive(1, 8'h99, 0, 0, 0);
        tick();
        check_out("rst.pre", 1'b1, 8'h99, 2'd1);
        check("rst.pre.bubbles", 32'(bus.bubbles), 32'hF);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        check_out("rst.mid", 1'b0, 8'h00, 2'd0);
        check("rst.mid.bubbles", 32'(bus.bubbles), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
